// File: rtl/divider6_pkg.sv
// Shared definitions for the 6-bit sequential restoring divider.
package divider6_pkg;

  localparam int DEF_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Quotient reported when the divisor is zero
  localparam logic [DEF_WIDTH-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/divider6_if.sv
// Operand/result bus between the calculator controller and the divider.
interface divider6_if import divider6_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             START;
  logic [WIDTH-1:0] A_DATA;
  logic [WIDTH-1:0] B_DATA;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] QUOTIENT;
  logic [WIDTH-1:0] REMAINDER;
  logic             DIV_ZERO;

  modport master (
    output START, A_DATA, B_DATA,
    input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_ZERO
  );

  modport slave (
    input  START, A_DATA, B_DATA,
    output BUSY, DONE, QUOTIENT, REMAINDER, DIV_ZERO
  );

endinterface

// File: rtl/divider6_div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// shifted partial remainder, keeping the difference only when it did not borrow.
module div_step import divider6_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   r_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] sub_b;
  logic [WIDTH:0] diff;
  logic           carry_out;

  assign sub_b = ~{1'b0, divisor};

  // Ripple of full adders: r_shift + ~divisor + 1; carry-out high means no borrow
  always_comb begin
    logic c;
    c    = 1'b1;
    diff = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      diff[i] = r_shift[i] ^ sub_b[i] ^ c;
      c       = (r_shift[i] & sub_b[i]) | (c & (r_shift[i] ^ sub_b[i]));
    end
    carry_out = c;
  end

  assign q_bit  = carry_out;
  assign r_next = carry_out ? diff : r_shift;

endmodule

// File: rtl/divider6.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// START is accepted whenever BUSY is low, so a new operation may begin in
// the DONE cycle of the previous one.
module divider6 import divider6_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic     CLK,
  input  logic     RST,
  divider6_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] DZ_Q =
    (WIDTH == DEF_WIDTH) ? WIDTH'(DZ_QUOTIENT) : '1;

  state_t           state, state_nxt;
  logic             busy, done, accept;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg, b_reg, q_work;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH:0]   r_shift, r_next;
  logic             q_bit;
  logic [WIDTH-1:0] quotient, remainder;
  logic             div_zero;
  logic [1:0]       unused_msbs;

  // Partial remainder stays below the divisor, so its top bit and the
  // quotient shift-out bit never carry information.
  assign unused_msbs = {r_reg[WIDTH], q_work[WIDTH-1]};

  assign r_shift = {r_reg[WIDTH-1:0], a_reg[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_shift (r_shift),
    .divisor (b_reg),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: zero divisor skips straight to FIN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (bus.START) state_nxt = (bus.B_DATA == '0) ? FIN : CALC;
        else           state_nxt = IDLE;
      end
      CALC:    if (cnt == '0) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy   = (state == CALC);
    done   = (state == FIN);
    accept = bus.START && !busy;
  end

  // Operand latch, iteration registers and held results
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_reg     <= '0;
      b_reg     <= '0;
      q_work    <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      a_reg    <= bus.A_DATA;
      b_reg    <= bus.B_DATA;
      q_work   <= '0;
      r_reg    <= '0;
      cnt      <= CNT_W'(WIDTH - 1);
      div_zero <= (bus.B_DATA == '0);
      if (bus.B_DATA == '0) begin
        quotient  <= DZ_Q;
        remainder <= bus.A_DATA;
      end
    end else if (state == CALC) begin
      r_reg  <= r_next;
      a_reg  <= {a_reg[WIDTH-2:0], 1'b0};
      q_work <= {q_work[WIDTH-2:0], q_bit};
      cnt    <= cnt - 1'b1;
      if (cnt == '0) begin
        quotient  <= {q_work[WIDTH-2:0], q_bit};
        remainder <= r_next[WIDTH-1:0];
      end
    end
  end

  assign bus.BUSY      = busy;
  assign bus.DONE      = done;
  assign bus.QUOTIENT  = quotient;
  assign bus.REMAINDER = remainder;
  assign bus.DIV_ZERO  = div_zero;

endmodule

// File: tb/tb_divider6.sv
// Self-checking bench for divider6: directed handshake scenarios followed by
// an exhaustive operand sweep, results scoreboarded against a reference model.
module tb_divider6;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  divider6_if #(.WIDTH(6)) bus ();

  divider6 #(.WIDTH(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [5:0] q;
    logic [5:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t model(input logic [5:0] a, input logic [5:0] b);
    exp_t e;
    if (b == 6'd0) begin
      e.q  = 6'd63;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [5:0] a, input logic [5:0] b);
    @(negedge CLK);
    bus.START  = 1'b1;
    bus.A_DATA = a;
    bus.B_DATA = b;
    sb.push_back(model(a, b));
  endtask

  // Wait (bounded) for DONE, then pop the expected result and compare
  task automatic wait_done(input string tag, input int lat0, input int exp_lat, input bit chk_busy);
    int   lat;
    exp_t e;
    lat = lat0;
    do begin
      @(negedge CLK);
      bus.START = 1'b0;
      lat++;
      if (chk_busy && !bus.DONE) check({tag, "_busy"}, bus.BUSY, 1);
    end while (!bus.DONE && lat < 20);
    check({tag, "_done"}, bus.DONE, 1);
    check({tag, "_latency"}, lat, exp_lat);
    if (bus.DONE) begin
      check({tag, "_busy_at_done"}, bus.BUSY, 0);
      check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_quotient"}, bus.QUOTIENT, e.q);
        check({tag, "_remainder"}, bus.REMAINDER, e.r);
        check({tag, "_div_zero"}, bus.DIV_ZERO, e.dz);
      end
    end
  endtask

  initial begin
    bit seen;
    bus.START  = 1'b0;
    bus.A_DATA = '0;
    bus.B_DATA = '0;

    // Reset state
    #2 RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_quotient", bus.QUOTIENT, 0);
    check("rst_remainder", bus.REMAINDER, 0);
    check("rst_div_zero", bus.DIV_ZERO, 0);
    RST = 1'b0;

    // 45 / 7 with full busy/latency tracking, then DONE must drop
    start_op(6'd45, 6'd7);
    wait_done("d45_7", 0, 7, 1'b1);
    @(negedge CLK);
    check("d45_7_done_pulse", bus.DONE, 0);

    start_op(6'd63, 6'd1);
    wait_done("d63_1", 0, 7, 1'b1);
    start_op(6'd5, 6'd9);
    wait_done("d5_9", 0, 7, 1'b1);
    start_op(6'd0, 6'd13);
    wait_done("d0_13", 0, 7, 1'b1);

    // Divide by zero, then a normal divide clears DIV_ZERO while results hold
    start_op(6'd20, 6'd0);
    wait_done("d20_0", 0, 1, 1'b1);
    start_op(6'd20, 6'd4);
    @(negedge CLK);
    bus.START = 1'b0;
    check("d20_4_dz_cleared", bus.DIV_ZERO, 0);
    check("d20_4_q_held", bus.QUOTIENT, 63);
    check("d20_4_r_held", bus.REMAINDER, 20);
    wait_done("d20_4", 1, 7, 1'b1);

    // START during CALC is ignored; operands change mid-iteration
    start_op(6'd50, 6'd6);
    @(negedge CLK);
    bus.START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    bus.START  = 1'b1;
    bus.A_DATA = 6'd9;
    bus.B_DATA = 6'd3;
    wait_done("d50_6", 3, 7, 1'b1);

    // START held in the FIN cycle is accepted back-to-back
    bus.START  = 1'b1;
    bus.A_DATA = 6'd9;
    bus.B_DATA = 6'd3;
    sb.push_back(model(6'd9, 6'd3));
    wait_done("d9_3_b2b", 0, 7, 1'b1);

    // Asynchronous reset mid-CALC aborts with no DONE
    start_op(6'd40, 6'd3);
    @(negedge CLK);
    bus.START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    check("abort_busy", bus.BUSY, 0);
    check("abort_done", bus.DONE, 0);
    check("abort_quotient", bus.QUOTIENT, 0);
    check("abort_remainder", bus.REMAINDER, 0);
    check("abort_div_zero", bus.DIV_ZERO, 0);
    sb.delete();
    @(negedge CLK);
    RST  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      seen |= bus.DONE;
    end
    check("abort_no_done", seen, 0);
    start_op(6'd40, 6'd3);
    wait_done("d40_3", 0, 7, 1'b1);

    // Exhaustive sweep of every operand pair
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        start_op(6'(a), 6'(b));
        wait_done("sweep", 0, (b == 0) ? 1 : 7, 1'b0);
      end
    end

    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
